// File: rtl/mux_cfg_chain_ctrl_if.sv
// Configuration-chain handshake bundle between a bitstream source and mux_cfg_chain_ctrl.
// TOTAL must equal NUM_MUX*SRAM_W of the attached controller.
interface mux_cfg_chain_ctrl_if #(
    parameter int TOTAL = 24
);
    logic             cfg_start;
    logic             cfg_din;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_done;
    logic             cfg_err;
    logic             ccff_tail;
    logic [TOTAL-1:0] sram;
    logic [TOTAL-1:0] sram_inv;

    modport master (
        output cfg_start, cfg_din, cfg_valid,
        input  cfg_ready, cfg_done, cfg_err, ccff_tail, sram, sram_inv
    );

    modport slave (
        input  cfg_start, cfg_din, cfg_valid,
        output cfg_ready, cfg_done, cfg_err, ccff_tail, sram, sram_inv
    );
endinterface

// File: rtl/mux_cfg_chain_ctrl.sv
// Serial configuration loader: shifts a TOTAL-bit frame in, then commits it atomically
// to a shadow register that drives the mux select lines.
module mux_cfg_chain_ctrl #(
    parameter int NUM_MUX = 4,
    parameter int SRAM_W  = 6
) (
    input  logic                 prog_clk,
    input  logic                 pReset,
    mux_cfg_chain_ctrl_if.slave  cfg
);
    localparam int TOTAL = NUM_MUX * SRAM_W;
    localparam int CNT_W = $clog2(TOTAL + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [TOTAL-1:0] sr_reg, sr_next;
    logic [TOTAL-1:0] sh_reg, sh_next;
    logic             err_reg, err_next;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sr_next    = sr_reg;
        sh_next    = sh_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE, DONE: begin
                // A start beats a stray valid in the same cycle, so the error clear wins.
                if (cfg.cfg_start) begin
                    state_next = LOAD;
                    cnt_next   = '0;
                    err_next   = 1'b0;
                end else if (cfg.cfg_valid) begin
                    err_next = 1'b1;
                end
            end
            LOAD: begin
                if (cfg.cfg_start) begin
                    cnt_next = '0;
                    err_next = 1'b1;
                end else if (cfg.cfg_valid) begin
                    sr_next  = {sr_reg[TOTAL-2:0], cfg.cfg_din};
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(TOTAL - 1))
                        state_next = COMMIT;
                end
            end
            COMMIT: begin
                sh_next    = sr_reg;
                state_next = DONE;
                if (cfg.cfg_start || cfg.cfg_valid)
                    err_next = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            sr_reg    <= '0;
            sh_reg    <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sr_reg    <= sr_next;
            sh_reg    <= sh_next;
            err_reg   <= err_next;
        end
    end

    assign cfg.cfg_ready = (state_reg == LOAD);
    assign cfg.cfg_done  = (state_reg == DONE);
    assign cfg.cfg_err   = err_reg;
    assign cfg.ccff_tail = sr_reg[TOTAL-1];

    // The shadow only changes in COMMIT, so each mux sees a glitch-free select during loading.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_MUX; gi++) begin : g_mux
            assign cfg.sram[gi*SRAM_W +: SRAM_W]     = sh_reg[gi*SRAM_W +: SRAM_W];
            assign cfg.sram_inv[gi*SRAM_W +: SRAM_W] = ~sh_reg[gi*SRAM_W +: SRAM_W];
        end
    endgenerate
endmodule

// File: tb/tb_mux_cfg_chain_ctrl.sv
// Bench for mux_cfg_chain_ctrl: a queue-based model of accepted bits predicts every output,
// and a second instance chained from ccff_tail checks the 24-beat delay through the chain.
module tb_mux_cfg_chain_ctrl;
    localparam int NUM_MUX = 4;
    localparam int SRAM_W  = 6;
    localparam int TOTAL   = NUM_MUX * SRAM_W;

    logic prog_clk = 1'b0;
    logic pReset   = 1'b0;
    always #5 prog_clk = ~prog_clk;

    mux_cfg_chain_ctrl_if #(.TOTAL(TOTAL)) cfg_if ();
    mux_cfg_chain_ctrl_if #(.TOTAL(TOTAL)) cfg2 ();

    mux_cfg_chain_ctrl #(.NUM_MUX(NUM_MUX), .SRAM_W(SRAM_W)) dut (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .cfg      (cfg_if.slave)
    );

    mux_cfg_chain_ctrl #(.NUM_MUX(NUM_MUX), .SRAM_W(SRAM_W)) dut2 (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .cfg      (cfg2.slave)
    );

    assign cfg2.cfg_start = cfg_if.cfg_start;
    assign cfg2.cfg_valid = cfg_if.cfg_valid;
    assign cfg2.cfg_din   = cfg_if.ccff_tail;

    int total = 0;
    int bad   = 0;

    // Model: phase 0=idle 1=load 2=commit 3=done; history of every accepted bit since reset.
    int               m_phase;
    int               m_cnt;
    bit               m_err;
    bit               m_hist[$];
    bit               m_hist2[$];
    logic [TOTAL-1:0] m_sram;
    logic [TOTAL-1:0] m_sram2;

    function automatic logic [TOTAL-1:0] last_frame(input bit h[$]);
        logic [TOTAL-1:0] v = '0;
        for (int i = h.size() - TOTAL; i < h.size(); i++) v = {v[TOTAL-2:0], h[i]};
        return v;
    endfunction

    function automatic bit exp_tail(input bit h[$]);
        return h[h.size() - TOTAL];
    endfunction

    function automatic logic [TOTAL+3:0] exp_vec();
        return {m_phase == 1, m_phase == 3, m_err, exp_tail(m_hist), m_sram};
    endfunction

    function automatic logic [TOTAL+3:0] dut_vec();
        return {cfg_if.cfg_ready, cfg_if.cfg_done, cfg_if.cfg_err, cfg_if.ccff_tail, cfg_if.sram};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_err = 0;
        m_hist.delete(); m_hist2.delete();
        for (int i = 0; i < TOTAL; i++) begin
            m_hist.push_back(1'b0);
            m_hist2.push_back(1'b0);
        end
        m_sram = '0; m_sram2 = '0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, return #1 after it.
    task automatic step(input bit s, input bit v, input bit d);
        cfg_if.cfg_start = s;
        cfg_if.cfg_valid = v;
        cfg_if.cfg_din   = d;
        @(posedge prog_clk);
        if (pReset) begin
            model_reset();
        end else begin
            case (m_phase)
                0, 3: begin
                    if (s) begin m_phase = 1; m_cnt = 0; m_err = 0; end
                    else if (v) m_err = 1;
                end
                1: begin
                    if (s) begin m_cnt = 0; m_err = 1; end
                    else if (v) begin
                        m_hist2.push_back(exp_tail(m_hist));
                        m_hist.push_back(d);
                        m_cnt++;
                        if (m_cnt == TOTAL) m_phase = 2;
                    end
                end
                default: begin
                    m_sram  = last_frame(m_hist);
                    m_sram2 = last_frame(m_hist2);
                    m_phase = 3;
                    if (s || v) m_err = 1;
                end
            endcase
        end
        #1;
        cfg_if.cfg_start = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_din   = 1'b0;
    endtask

    task automatic do_reset();
        pReset = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);
        pReset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (cfg_if.sram !== '0 || cfg_if.sram_inv !== '1) begin
            bad++;
            $display("FAIL reset_sram: sram=%h inv=%h want 0/all-ones", cfg_if.sram, cfg_if.sram_inv);
        end
        total++;
        if ({cfg_if.cfg_ready, cfg_if.cfg_done, cfg_if.cfg_err, cfg_if.ccff_tail} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: rdy/done/err/tail=%b want 0000",
                     {cfg_if.cfg_ready, cfg_if.cfg_done, cfg_if.cfg_err, cfg_if.ccff_tail});
        end
    endtask

    task automatic test_frame_a5();
        logic [TOTAL-1:0] val = 24'hA5A5A5;
        do_reset();
        step(1, 0, 0);
        for (int i = TOTAL - 1; i >= 0; i--) begin
            total++;
            if (cfg_if.cfg_ready !== 1'b1 || cfg_if.sram !== '0) begin
                bad++;
                $display("FAIL a5_load: beat %0d ready=%b sram=%h want 1/0", i, cfg_if.cfg_ready, cfg_if.sram);
            end
            step(0, 1, val[i]);
        end
        total++;
        if (cfg_if.cfg_done !== 1'b0 || cfg_if.sram !== '0) begin
            bad++;
            $display("FAIL a5_commit: done=%b sram=%h want 0/0 one cycle after last beat", cfg_if.cfg_done, cfg_if.sram);
        end
        step(0, 0, 0);
        total++;
        if (cfg_if.cfg_done !== 1'b1 || cfg_if.sram !== val || cfg_if.sram_inv !== ~val || cfg_if.cfg_err !== 1'b0) begin
            bad++;
            $display("FAIL a5_done: done=%b sram=%h inv=%h err=%b want 1/%h/%h/0",
                     cfg_if.cfg_done, cfg_if.sram, cfg_if.sram_inv, cfg_if.cfg_err, val, ~val);
        end
    endtask

    task automatic test_frame_toggle();
        logic [TOTAL-1:0] val = 24'hA5A5A5;
        do_reset();
        step(1, 0, 0);
        for (int i = TOTAL - 1; i >= 0; i--) begin
            if (i != TOTAL - 1) begin
                step(0, 0, 0);
                total++;
                if (cfg_if.cfg_ready !== 1'b1 || cfg_if.sram !== '0) begin
                    bad++;
                    $display("FAIL toggle_gap: beat %0d ready=%b sram=%h want 1/0", i, cfg_if.cfg_ready, cfg_if.sram);
                end
            end
            step(0, 1, val[i]);
        end
        step(0, 0, 0);
        total++;
        if (cfg_if.cfg_done !== 1'b1 || cfg_if.sram !== val) begin
            bad++;
            $display("FAIL toggle_done: done=%b sram=%h want 1/%h", cfg_if.cfg_done, cfg_if.sram, val);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [TOTAL-1:0] ones = '1;
        do_reset();
        step(1, 0, 0);
        for (int i = 0; i < TOTAL; i++) step(0, 1, 1'b1);
        step(0, 0, 0);
        total++;
        if (cfg_if.sram !== ones) begin
            bad++;
            $display("FAIL ff_commit: sram=%h want %h", cfg_if.sram, ones);
        end
        step(1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 1'b0);
        do_reset();
        total++;
        if (cfg_if.sram !== '0 || cfg_if.cfg_done !== 1'b0 || cfg_if.cfg_ready !== 1'b0 || cfg_if.ccff_tail !== 1'b0) begin
            bad++;
            $display("FAIL midload_reset: sram=%h done=%b ready=%b tail=%b want 0/0/0/0",
                     cfg_if.sram, cfg_if.cfg_done, cfg_if.cfg_ready, cfg_if.ccff_tail);
        end
        // Idle after reset: a start must be needed before beats are taken again.
        step(0, 1, 1'b1);
        total++;
        if (cfg_if.cfg_ready !== 1'b0 || cfg_if.cfg_err !== 1'b1) begin
            bad++;
            $display("FAIL midload_idle: ready=%b err=%b want 0/1", cfg_if.cfg_ready, cfg_if.cfg_err);
        end
    endtask

    task automatic test_restart();
        logic [TOTAL-1:0] val = 24'h000001;
        do_reset();
        step(1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 1'b1);
        step(1, 1, 1'b1);
        for (int i = TOTAL - 1; i >= 0; i--) step(0, 1, val[i]);
        total++;
        if (cfg_if.cfg_err !== 1'b1 || cfg_if.cfg_done !== 1'b0) begin
            bad++;
            $display("FAIL restart_commit: err=%b done=%b want 1/0", cfg_if.cfg_err, cfg_if.cfg_done);
        end
        step(0, 0, 0);
        total++;
        if (cfg_if.sram !== val || cfg_if.cfg_err !== 1'b1 || cfg_if.cfg_done !== 1'b1) begin
            bad++;
            $display("FAIL restart_done: sram=%h err=%b done=%b want %h/1/1",
                     cfg_if.sram, cfg_if.cfg_err, cfg_if.cfg_done, val);
        end
        step(1, 1, 1'b0);
        total++;
        if (cfg_if.cfg_err !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL restart_clear: err=%b ready=%b want 0/1", cfg_if.cfg_err, cfg_if.cfg_ready);
        end
    endtask

    task automatic test_idle_valid();
        do_reset();
        step(1, 0, 0);
        for (int i = 0; i < TOTAL; i++) step(0, 1, 1'b1);
        step(0, 0, 0);
        do_reset();
        step(0, 1, 1'b1);
        step(0, 1, 1'b1);
        total++;
        if (cfg_if.cfg_err !== 1'b1 || cfg_if.ccff_tail !== 1'b0) begin
            bad++;
            $display("FAIL idle_valid: err=%b tail=%b want 1/0", cfg_if.cfg_err, cfg_if.ccff_tail);
        end
        step(1, 0, 0);
        step(0, 1, 1'b1);
        total++;
        if (cfg_if.cfg_err !== 1'b0 || cfg_if.ccff_tail !== 1'b0) begin
            bad++;
            $display("FAIL idle_clear: err=%b tail=%b want 0/0", cfg_if.cfg_err, cfg_if.ccff_tail);
        end
    endtask

    task automatic test_back_to_back();
        logic [TOTAL-1:0] v1;
        logic [TOTAL-1:0] v2;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            v1 = TOTAL'($urandom);
            v2 = TOTAL'($urandom);
            step(1, 0, 0);
            for (int i = TOTAL - 1; i >= 0; i--) step(0, 1, v1[i]);
            step(0, 0, 0);
            step(1, 0, 0);
            for (int i = TOTAL - 1; i >= 0; i--) begin
                total++;
                if (cfg_if.sram !== v1) begin
                    bad++;
                    $display("FAIL b2b_hold: frame %0d sram=%h want %h", f, cfg_if.sram, v1);
                end
                step(0, 1, v2[i]);
            end
            step(0, 0, 0);
            total++;
            if (cfg_if.sram !== v2 || cfg2.sram !== v1) begin
                bad++;
                $display("FAIL b2b_chain: frame %0d sram=%h chained=%h want %h/%h", f, cfg_if.sram, cfg2.sram, v2, v1);
            end
        end
    endtask

    task automatic test_random();
        bit s;
        bit v;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            s = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) pReset = 1'b1;
            step(s, v, 1'(($urandom)));
            pReset = 1'b0;
            total++;
            if (dut_vec() !== exp_vec() || cfg_if.sram_inv !== ~m_sram) begin
                bad++;
                $display("FAIL random: cyc %0d rdy/done/err/tail/sram=%h want %h", c, dut_vec(), exp_vec());
            end
            total++;
            if (cfg2.ccff_tail !== exp_tail(m_hist2) || cfg2.sram !== m_sram2) begin
                bad++;
                $display("FAIL chain: cyc %0d tail2=%b sram2=%h want %b/%h",
                         c, cfg2.ccff_tail, cfg2.sram, exp_tail(m_hist2), m_sram2);
            end
        end
    endtask

    initial begin
        cfg_if.cfg_start = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_din   = 1'b0;
        model_reset();
        test_reset();
        test_frame_a5();
        test_frame_toggle();
        test_reset_mid_load();
        test_restart();
        test_idle_valid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux_cfg_chain_ctrl.md
MUX_CFG_CHAIN_CTRL -- requirements
Module: mux_cfg_chain_ctrl

Interface
REQ-001 SHALL have parameter NUM_MUX, default 4: number of downstream mux_tree_tapbuf instances configured.
REQ-002 SHALL have parameter SRAM_W, default 6: select bits per mux.
REQ-003 SHALL define TOTAL = NUM_MUX*SRAM_W (default 24) as the frame length in bits.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 Ports SHALL be:
- prog_clk  in  1  configuration clock; all state changes on its rising edge.
- pReset  in  1  synchronous, active-high reset.
- cfg_start  in  1  single-cycle request to begin a frame.
- cfg_din  in  1  serial bitstream data.
- cfg_valid  in  1  cfg_din is valid this cycle.
- cfg_ready  out  1  block accepts a bit this cycle.
- cfg_done  out  1  a committed frame is driving sram.
- cfg_err  out  1  sticky protocol-error flag.
- ccff_tail  out  1  shift-register MSB, for daisy-chaining.
- sram  out  TOTAL  committed select bits; mux k uses sram[k*SRAM_W +: SRAM_W].
- sram_inv  out  TOTAL  bitwise complement of sram.

Function
REQ-006 SHALL implement FSM states IDLE, LOAD, COMMIT, DONE.
REQ-007 SHALL hold a TOTAL-bit shift register sr, a TOTAL-bit shadow register sh, and a bit counter cnt of width clog2(TOTAL+1).
REQ-008 A beat SHALL be a cycle with cfg_valid=1 and cfg_ready=1.
REQ-009 cfg_ready SHALL be 1 only in LOAD, driven from state (no combinational path from cfg_valid).
REQ-010 On each beat: sr <= {sr[TOTAL-2:0], cfg_din}; cnt <= cnt+1.
REQ-011 After a full frame, the first bit accepted SHALL sit in sr[TOTAL-1] and the last in sr[0].
REQ-012 In IDLE or DONE, cfg_start=1 SHALL move to LOAD, clear cnt and clear cfg_err; sr is not cleared.
REQ-013 In LOAD, the beat that takes cnt from TOTAL-1 to TOTAL SHALL move to COMMIT the next cycle.
REQ-014 COMMIT SHALL last exactly one cycle: sh <= sr, then go to DONE.
REQ-015 Latency: last beat accepted in cycle t -> COMMIT in t+1 -> new sram and cfg_done=1 visible in t+2.
REQ-016 cfg_done SHALL be 1 exactly in DONE.
REQ-017 sram SHALL equal sh, and sram_inv SHALL equal ~sh at all times.
REQ-018 sh SHALL change only in COMMIT, so sram is stable while a frame is loading; the old configuration stays live until commit.
REQ-019 ccff_tail SHALL equal sr[TOTAL-1] combinationally.
REQ-020 cfg_start=1 in LOAD SHALL restart the frame: cnt <= 0, stay in LOAD, set cfg_err=1, and ignore any beat in that cycle (start wins over a simultaneous beat).
REQ-021 cfg_start=1 in COMMIT SHALL be ignored and SHALL set cfg_err=1.
REQ-022 cfg_valid=1 in IDLE, COMMIT or DONE SHALL leave sr and cnt unchanged and set cfg_err=1.
REQ-023 cfg_start and cfg_valid both 1 in IDLE or DONE: the start is taken, and cfg_err ends the cycle at 0 (the clear wins).
REQ-024 cfg_err SHALL be sticky: cleared only by pReset or by an accepted start from IDLE or DONE.
REQ-025 cnt SHALL never exceed TOTAL; no beats are accepted outside LOAD.

Reset
REQ-026 pReset=1 at a rising edge SHALL force: state=IDLE, cnt=0, sr=0, sh=0, cfg_err=0.
REQ-027 Outputs during and after reset SHALL be: sram=0, sram_inv=all ones, cfg_ready=0, cfg_done=0, ccff_tail=0.
REQ-028 pReset SHALL take priority over all inputs in every state, including mid-LOAD and COMMIT; a partial frame is discarded.

Verification
REQ-029 Reset, then start, then 24 beats of 0xA5A5A5 sent MSB-first with valid held high -> cfg_done rises 2 cycles after the last beat; sram=0xA5A5A5; sram_inv=0x5A5A5A; cfg_err=0.
REQ-030 Same frame with cfg_valid toggling 1/0 every cycle -> identical sram; cfg_ready=1 throughout LOAD; sram stays 0 until commit.
REQ-031 Frame 0xFFFFFF committed; a second start, then 10 beats, then pReset -> sram=0, cfg_done=0, state IDLE.
REQ-032 Start, 5 beats, then start with a simultaneous valid, then 24 beats of 0x000001 -> sram=0x000001; cfg_err=1 until the next start from DONE.
REQ-033 cfg_valid=1 in IDLE -> cfg_err=1; sr unchanged; the next start clears cfg_err.
REQ-034 During LOAD, ccff_tail equals the bit accepted 24 beats earlier; check via a chained second instance fed from ccff_tail.
